frame_write_sequencer: RTL

- Configuration sequencer for one fabric column.
- Accepts a 32-bit command/data word stream on a valid/ready handshake and assembles one frame (NumRows words) into the column-wide FrameData bus.
- Then pulses the matching FrameStrobe bit for exactly one cycle, and the column's tiles latch the frame.
- Sits between the bitstream loader and the column's FrameData/FrameStrobe inputs.

---
 rtl/frame_write_sequencer.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/frame_write_sequencer.sv
// Column configuration sequencer: takes a header plus NumRows data words from a
// valid/ready stream, assembles the frame and fires a single one-hot FrameStrobe.
module frame_write_sequencer #(
  parameter int unsigned MaxFramesPerCol = 20,
  parameter int unsigned FrameBitsPerRow = 32,
  parameter int unsigned NumRows         = 4,
  parameter logic [7:0]  ColumnId        = 8'd0
) (
  input  logic                               UserCLK,
  input  logic                               resetn,
  input  logic [FrameBitsPerRow-1:0]         s_data,
  input  logic                               s_valid,
  output logic                               s_ready,
  output logic [NumRows*FrameBitsPerRow-1:0] FrameData,
  output logic [MaxFramesPerCol-1:0]         FrameStrobe,
  output logic                               busy,
  output logic                               err
);

  localparam int unsigned DataW = NumRows * FrameBitsPerRow;
  localparam int unsigned RowW  = (NumRows > 1) ? $clog2(NumRows) : 1;
  localparam int unsigned IdxW  = 5;
  localparam logic [3:0]  HdrOpcode = 4'hA;
  localparam logic [RowW-1:0] LastRow = RowW'(NumRows - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  state_t                     state_q, state_d;
  logic                       skip_q, skip_d;
  logic [IdxW-1:0]            idx_q, idx_d;
  logic [RowW-1:0]            row_q, row_d;
  logic [DataW-1:0]           frame_data_d;
  logic [MaxFramesPerCol-1:0] strobe_d;
  logic                       ready_d;
  logic                       busy_d;
  logic                       err_d;
  logic                       xfer;

  logic [3:0]      hdr_opcode;
  logic [7:0]      hdr_column;
  logic [IdxW-1:0] hdr_idx;

  // Header fields; the remaining header bits carry no meaning.
  assign hdr_opcode = s_data[31:28];
  assign hdr_column = s_data[15:8];
  assign hdr_idx    = s_data[4:0];
  assign xfer       = s_valid & s_ready;

  // State and output registers.
  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      skip_q      <= 1'b0;
      idx_q       <= '0;
      row_q       <= '0;
      FrameData   <= '0;
      FrameStrobe <= '0;
      s_ready     <= 1'b1;
      busy        <= 1'b0;
      err         <= 1'b0;
    end else begin
      state_q     <= state_d;
      skip_q      <= skip_d;
      idx_q       <= idx_d;
      row_q       <= row_d;
      FrameData   <= frame_data_d;
      FrameStrobe <= strobe_d;
      s_ready     <= ready_d;
      busy        <= busy_d;
      err         <= err_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    skip_d       = skip_q;
    idx_d        = idx_q;
    row_d        = row_q;
    frame_data_d = FrameData;
    err_d        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (xfer) begin
          if (hdr_opcode != HdrOpcode) begin
            err_d = 1'b1;
          end else if (32'(hdr_idx) >= MaxFramesPerCol) begin
            err_d   = 1'b1;
            skip_d  = 1'b1;
            state_d = LOAD;
          end else if (hdr_column != ColumnId) begin
            skip_d  = 1'b1;
            state_d = LOAD;
          end else begin
            idx_d   = hdr_idx;
            skip_d  = 1'b0;
            state_d = LOAD;
          end
        end
      end

      LOAD: begin
        if (xfer) begin
          if (!skip_q) begin
            for (int r = 0; r < int'(NumRows); r++) begin
              if (row_q == RowW'(r)) begin
                frame_data_d[r*FrameBitsPerRow +: FrameBitsPerRow] = s_data;
              end
            end
          end
          if (row_q == LastRow) begin
            row_d   = '0;
            state_d = skip_q ? IDLE : STROBE;
          end else begin
            row_d = row_q + RowW'(1);
          end
        end
      end

      STROBE: state_d = HOLD;

      HOLD: state_d = IDLE;

      default: state_d = IDLE;
    endcase

    // Outputs are registered, so they are decoded from the upcoming state.
    ready_d  = (state_d == IDLE) || (state_d == LOAD);
    busy_d   = (state_d != IDLE);
    strobe_d = (state_d == STROBE) ? (MaxFramesPerCol'(1) << idx_d) : '0;
  end

  // Structural invariants of the strobe/error outputs.
  a_strobe_onehot0 : assert property (@(posedge UserCLK) disable iff (!resetn)
    $onehot0(FrameStrobe));
  a_strobe_in_state : assert property (@(posedge UserCLK) disable iff (!resetn)
    (|FrameStrobe) |-> (state_q == STROBE));
  a_err_not_strobe : assert property (@(posedge UserCLK) disable iff (!resetn)
    !(err && (|FrameStrobe)));

endmodule
